sdram_port_bridge: RTL

Client-side bridge for one SDRAM controller port. It accepts posted writes into a small FIFO and single-outstanding reads from a bus-side agent, such as the Apple II bus snooper or the video fetch logic. It serialises these requests onto the port's wr/rd/available/ready handshake. Read-after-write ordering is preserved, and a pending read cannot be starved by later writes.

---
 rtl/sdram_port_bridge_if.sv | 47 ++++
 rtl/sdram_port_bridge.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_bridge_if
// Brief    : Bus-agent and controller-port signal bundle for sdram_port_bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_port_bridge_if #(
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 16,
    parameter int DQM_WIDTH    = 2,
    parameter int OUTPUT_WIDTH = 16
);
    logic                    wr_req;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DQM_WIDTH-1:0]    wr_be;
    logic                    wr_full;
    logic                    wr_overflow;
    logic                    rd_req;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_busy;
    logic                    rd_valid;
    logic [OUTPUT_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0]   port_addr;
    logic [DATA_WIDTH-1:0]   port_data;
    logic [DQM_WIDTH-1:0]    port_byte_en;
    logic                    port_wr;
    logic                    port_rd;
    logic                    port_available;
    logic                    port_ready;
    logic [OUTPUT_WIDTH-1:0] port_q;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
               port_available, port_ready, port_q,
        output wr_full, wr_overflow, rd_busy, rd_valid, rd_data,
               port_addr, port_data, port_byte_en, port_wr, port_rd
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
               port_available, port_ready, port_q,
        input  wr_full, wr_overflow, rd_busy, rd_valid, rd_data,
               port_addr, port_data, port_byte_en, port_wr, port_rd
    );
endinterface
`default_nettype wire

// File: rtl/sdram_port_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_bridge
// Brief    : Posted-write FIFO plus single read slot serialised onto one
//            SDRAM controller port, preserving read-after-write order.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_bridge #(
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 16,
    parameter int DQM_WIDTH    = 2,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_port_bridge_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WR = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d, ahead_q, ahead_d;
    logic                    full_q, full_d, ovf_q, ovf_d;
    logic                    rd_busy_q, rd_busy_d, rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [OUTPUT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0]   port_addr_q, port_addr_d;
    logic [DATA_WIDTH-1:0]   port_data_q, port_data_d;
    logic [DQM_WIDTH-1:0]    port_be_q, port_be_d;
    logic                    port_wr_q, port_wr_d, port_rd_q, port_rd_d;

    logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
    logic [DQM_WIDTH-1:0]    mem_be   [FIFO_DEPTH];

    logic                    push, pop, rd_acc, rd_pend;
    logic [CNT_W-1:0]        cnt_push, ahead_eff;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [DQM_WIDTH-1:0]    head_be;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= bus.wr_addr;
            mem_data[wr_ptr_q] <= bus.wr_data;
            mem_be[wr_ptr_q]   <= bus.wr_be;
        end
    end

    always_comb begin
        push      = bus.wr_req && !full_q;
        rd_acc    = bus.rd_req && !rd_busy_q;
        cnt_push  = count_q + CNT_W'(push);
        rd_pend   = rd_busy_q || rd_acc;
        ahead_eff = rd_acc ? cnt_push : ahead_q;
        // An empty FIFO forwards the incoming write so it can issue next cycle.
        if (count_q == '0) begin
            head_addr = bus.wr_addr;
            head_data = bus.wr_data;
            head_be   = bus.wr_be;
        end else begin
            head_addr = mem_addr[rd_ptr_q];
            head_data = mem_data[rd_ptr_q];
            head_be   = mem_be[rd_ptr_q];
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        port_wr_d   = 1'b0;
        port_rd_d   = 1'b0;
        rd_valid_d  = 1'b0;
        port_addr_d = port_addr_q;
        port_data_d = port_data_q;
        port_be_d   = port_be_q;
        rd_data_d   = rd_data_q;
        rd_addr_d   = rd_acc ? bus.rd_addr : rd_addr_q;
        rd_busy_d   = rd_busy_q || rd_acc;

        case (state_q)
            ST_IDLE: begin
                if (bus.port_available) begin
                    if (rd_pend && ahead_eff == '0) begin
                        port_rd_d   = 1'b1;
                        port_addr_d = rd_addr_d;
                        state_d     = ST_WAIT_RD;
                    end else if (cnt_push != '0) begin
                        pop         = 1'b1;
                        port_wr_d   = 1'b1;
                        port_addr_d = head_addr;
                        port_data_d = head_data;
                        port_be_d   = head_be;
                        state_d     = ST_WAIT_WR;
                    end
                end
            end
            ST_WAIT_WR: begin
                if (bus.port_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (bus.port_ready) begin
                    rd_data_d  = bus.port_q;
                    rd_valid_d = 1'b1;
                    rd_busy_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        count_d  = cnt_push - CNT_W'(pop);
        full_d   = (count_d == C_DEPTH);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        ovf_d    = ovf_q || (bus.wr_req && full_q);
        ahead_d  = (pop && ahead_eff != '0) ? ahead_eff - CNT_W'(1) : ahead_eff;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ahead_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            port_addr_q <= '0;
            port_data_q <= '0;
            port_be_q   <= '0;
            port_wr_q   <= 1'b0;
            port_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ahead_q     <= ahead_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            rd_busy_q   <= rd_busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            port_addr_q <= port_addr_d;
            port_data_q <= port_data_d;
            port_be_q   <= port_be_d;
            port_wr_q   <= port_wr_d;
            port_rd_q   <= port_rd_d;
        end
    end

    assign bus.wr_full      = full_q;
    assign bus.wr_overflow  = ovf_q;
    assign bus.rd_busy      = rd_busy_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.port_addr    = port_addr_q;
    assign bus.port_data    = port_data_q;
    assign bus.port_byte_en = port_be_q;
    assign bus.port_wr      = port_wr_q;
    assign bus.port_rd      = port_rd_q;
endmodule
`default_nettype wire
